// File: rtl/mem_dump_ctrl_if.sv
// Bus bundle between mem_dump_ctrl, the DataMemory read port, the CU state tap and the dump sink.
// master = dump engine side, slave = memory/sink/CU side.
interface mem_dump_ctrl_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 5,
    parameter int STATE_WIDTH = 5
) ();
    logic [STATE_WIDTH-1:0] cu_state;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   dump_valid;
    logic                   dump_ready;
    logic [ADDR_WIDTH-1:0]  dump_addr;
    logic [DATA_WIDTH-1:0]  dump_data;
    logic                   dump_active;
    logic                   done;
    logic                   timed_out;

    modport master (
        input  cu_state, mem_rdata, dump_ready,
        output mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data,
               dump_active, done, timed_out
    );

    modport slave (
        output cu_state, mem_rdata, dump_ready,
        input  mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data,
               dump_active, done, timed_out
    );
endinterface

// File: rtl/mem_dump_ctrl.sv
// End-of-kernel monitor: on CU end state (or watchdog expiry) streams a DataMemory window out over valid/ready.
// Define MEM_DUMP_WATCHDOG_EN to build the RUN-state watchdog trigger; otherwise timed_out is tied low.
module mem_dump_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 5,
    parameter int STATE_WIDTH    = 5,
    parameter int END_STATE      = 19,
    parameter int BASE_ADDR      = 0,
    parameter int DUMP_WORDS     = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic            clk,
    input logic            reset,
    mem_dump_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(DUMP_WORDS + 1);
    localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(DUMP_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0]  BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [STATE_WIDTH-1:0] END_CODE = STATE_WIDTH'(END_STATE);

    if (DUMP_WORDS < 1 || DUMP_WORDS > (1 << ADDR_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("mem_dump_ctrl: DUMP_WORDS or TIMEOUT_CYCLES out of range");
    end

    // RUN idle | ISSUE read strobe | CAPTURE latch word | SEND wait handshake | DONE terminal
    typedef enum logic [2:0] {RUN, ISSUE, CAPTURE, SEND, DONE} state_e;

    state_e                 state_q;
    logic                   mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic                   dump_valid_q;
    logic [ADDR_WIDTH-1:0]  dump_addr_q;
    logic [DATA_WIDTH-1:0]  dump_data_q;
    logic                   dump_active_q;
    logic                   done_q;
    logic [CNT_W-1:0]       idx_q;
    logic [CNT_W-1:0]       idx_d;
    logic                   end_seen;
    logic                   wdog_fire;

    assign end_seen   = (bus.cu_state == END_CODE);
    assign mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
    assign idx_d      = idx_q + CNT_W'(1);

`ifdef MEM_DUMP_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_q;
    logic            timed_out_q;

    assign wdog_fire = (wdog_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (state_q == RUN && !wdog_fire) begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end

    assign bus.timed_out = timed_out_q;
`else
    assign wdog_fire     = 1'b0;
    assign bus.timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= BASE;
            dump_valid_q  <= 1'b0;
            dump_addr_q   <= '0;
            dump_data_q   <= '0;
            dump_active_q <= 1'b0;
            done_q        <= 1'b0;
            idx_q         <= '0;
`ifdef MEM_DUMP_WATCHDOG_EN
            timed_out_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                RUN: begin
                    if (end_seen || wdog_fire) begin
                        state_q       <= ISSUE;
                        mem_rd_en_q   <= 1'b1;
                        dump_active_q <= 1'b1;
`ifdef MEM_DUMP_WATCHDOG_EN
                        // a simultaneous end state wins over the watchdog
                        timed_out_q   <= !end_seen;
`endif
                    end
                end
                ISSUE: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= CAPTURE;
                end
                CAPTURE: begin
                    dump_data_q  <= bus.mem_rdata;
                    dump_addr_q  <= mem_addr_q;
                    dump_valid_q <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    if (bus.dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q        <= 1'b1;
                            dump_active_q <= 1'b0;
                            state_q       <= DONE;
                        end else begin
                            idx_q       <= idx_d;
                            mem_addr_q  <= mem_addr_d;
                            mem_rd_en_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_addr   = dump_addr_q;
    assign bus.dump_data   = dump_data_q;
    assign bus.dump_active = dump_active_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl: three instances (main window, wrapping window, short watchdog)
// each with a synchronous RAM model and a scoreboard queue of expected {addr, data} words.
`timescale 1ns/1ps
module tb_mem_dump_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_w, rst_d;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc;
    int   hs_m, hs_w, hs_d;
    logic [15:0] ram [32];
    logic [31:0] q_m[$];
    logic [31:0] q_w[$];
    logic [31:0] q_d[$];

    mem_dump_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5)) if_m ();
    mem_dump_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5)) if_w ();
    mem_dump_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5)) if_d ();

    mem_dump_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5), .END_STATE(19),
                    .BASE_ADDR(0), .DUMP_WORDS(32), .TIMEOUT_CYCLES(100000))
        u_main (.clk(clk), .reset(rst_m), .bus(if_m));
    mem_dump_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5), .END_STATE(19),
                    .BASE_ADDR(30), .DUMP_WORDS(4), .TIMEOUT_CYCLES(100000))
        u_wrap (.clk(clk), .reset(rst_w), .bus(if_w));
    mem_dump_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STATE_WIDTH(5), .END_STATE(19),
                    .BASE_ADDR(0), .DUMP_WORDS(32), .TIMEOUT_CYCLES(50))
        u_wd (.clk(clk), .reset(rst_d), .bus(if_d));

    always @(posedge clk) begin
        if (if_m.mem_rd_en) if_m.mem_rdata <= ram[if_m.mem_addr];
        if (if_w.mem_rd_en) if_w.mem_rdata <= ram[if_w.mem_addr];
        if (if_d.mem_rd_en) if_d.mem_rdata <= ram[if_d.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_words(input int which, input int base, input int n);
        logic [4:0]  a;
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            a = 5'(base + i);
            e = {11'b0, a, 16'(a + 100)};
            case (which)
                0: q_m.push_back(e);
                1: q_w.push_back(e);
                default: q_d.push_back(e);
            endcase
        end
    endtask

    task automatic chk_rst_m();
        chk("rst_rden",   32'(if_m.mem_rd_en),   0);
        chk("rst_maddr",  32'(if_m.mem_addr),    0);
        chk("rst_valid",  32'(if_m.dump_valid),  0);
        chk("rst_daddr",  32'(if_m.dump_addr),   0);
        chk("rst_ddata",  32'(if_m.dump_data),   0);
        chk("rst_active", 32'(if_m.dump_active), 0);
        chk("rst_done",   32'(if_m.done),        0);
        chk("rst_tout",   32'(if_m.timed_out),   0);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_m && if_m.dump_valid && if_m.dump_ready) begin
            hs_m++;
            chk("sb_m_expected", 32'(q_m.size() > 0), 1);
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                chk("sb_m_word", {11'b0, if_m.dump_addr, if_m.dump_data}, e);
            end
        end
        if (!rst_w && if_w.dump_valid && if_w.dump_ready) begin
            hs_w++;
            chk("sb_w_expected", 32'(q_w.size() > 0), 1);
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                chk("sb_w_word", {11'b0, if_w.dump_addr, if_w.dump_data}, e);
            end
        end
        if (!rst_d && if_d.dump_valid && if_d.dump_ready) begin
            hs_d++;
            chk("sb_d_expected", 32'(q_d.size() > 0), 1);
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                chk("sb_d_word", {11'b0, if_d.dump_addr, if_d.dump_data}, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int found;
        int extra;
        int n;
        for (int i = 0; i < 32; i++) ram[i] = 16'(i + 100);
        rst_m = 1'b1; rst_w = 1'b1; rst_d = 1'b1;
        hs_m = 0; hs_w = 0; hs_d = 0; cyc = 0;
        if_m.cu_state = '0; if_m.dump_ready = 1'b0;
        if_w.cu_state = '0; if_w.dump_ready = 1'b0;
        if_d.cu_state = '0; if_d.dump_ready = 1'b0;
        tick();
        tick();

        // normal end at cycle 10
        rst_m = 1'b0; cyc = 0;
        chk_rst_m();
        if_m.dump_ready = 1'b1;
        repeat (10) tick();
        if_m.cu_state = 5'd19;
        expect_words(0, 0, 32);
        tick();
        if_m.cu_state = '0;
        chk("n_active_t1", 32'(if_m.dump_active), 1);
        chk("n_rden_t1",   32'(if_m.mem_rd_en),   1);
        chk("n_maddr_t1",  32'(if_m.mem_addr),    0);
        tick();
        chk("n_rden_t2",   32'(if_m.mem_rd_en),   0);
        chk("n_valid_t2",  32'(if_m.dump_valid),  0);
        tick();
        chk("n_valid_t3",  32'(if_m.dump_valid),  1);
        chk("n_data_t3",   32'(if_m.dump_data),   100);
        while (cyc < 106) tick();
        chk("n_done_106",  32'(if_m.done),        0);
        tick();
        chk("n_done_107",  32'(if_m.done),        1);
        chk("n_active_end", 32'(if_m.dump_active), 0);
        chk("n_tout",      32'(if_m.timed_out),   0);
        chk("n_hs",        32'(hs_m),             32);
        chk("n_q_left",    32'(q_m.size()),       0);

        // terminal: cu_state sweep after done
        extra = 0;
        for (int v = 0; v < 32; v++) begin
            if_m.cu_state = 5'(v);
            tick();
            if (if_m.mem_rd_en || if_m.dump_valid) extra++;
        end
        if_m.cu_state = '0;
        chk("term_extra", 32'(extra), 0);
        chk("term_done",  32'(if_m.done), 1);
        chk("term_hs",    32'(hs_m), 32);

        // backpressure on word 3
        rst_m = 1'b1; tick(); rst_m = 1'b0;
        q_m.delete(); hs_m = 0;
        if_m.dump_ready = 1'b1;
        tick(); tick();
        if_m.cu_state = 5'd19;
        expect_words(0, 0, 32);
        tick();
        if_m.cu_state = '0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (if_m.dump_valid && if_m.dump_addr == 5'd3) found = 1;
            else tick();
        end
        chk("bp_found", 32'(found), 1);
        if_m.dump_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(if_m.dump_valid), 1);
            chk("bp_data",  32'(if_m.dump_data),  103);
            chk("bp_addr",  32'(if_m.dump_addr),  3);
            tick();
        end
        chk("bp_valid_hold", 32'(if_m.dump_valid), 1);
        chk("bp_hs_hold",    32'(hs_m), 3);
        if_m.dump_ready = 1'b1;
        for (int k = 0; k < 150 && !if_m.done; k++) tick();
        chk("bp_done",   32'(if_m.done), 1);
        chk("bp_hs",     32'(hs_m), 32);
        chk("bp_q_left", 32'(q_m.size()), 0);

        // reset during word 5, then a full restart
        rst_m = 1'b1; tick(); rst_m = 1'b0;
        q_m.delete(); hs_m = 0;
        if_m.cu_state = 5'd19;
        expect_words(0, 0, 32);
        tick();
        if_m.cu_state = '0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (if_m.dump_valid && if_m.dump_addr == 5'd5) found = 1;
            else tick();
        end
        chk("rs_found", 32'(found), 1);
        rst_m = 1'b1;
        tick();
        chk_rst_m();
        rst_m = 1'b0;
        q_m.delete(); hs_m = 0;
        repeat (3) tick();
        chk("rs_no_done", 32'(if_m.done), 0);
        chk("rs_idle",    32'(if_m.mem_rd_en), 0);
        if_m.cu_state = 5'd19;
        expect_words(0, 0, 32);
        tick();
        if_m.cu_state = '0;
        chk("rs_maddr", 32'(if_m.mem_addr), 0);
        for (int k = 0; k < 150 && !if_m.done; k++) tick();
        chk("rs_done",   32'(if_m.done), 1);
        chk("rs_hs",     32'(hs_m), 32);
        chk("rs_q_left", 32'(q_m.size()), 0);

        // wrapping window 30,31,0,1
        rst_w = 1'b0;
        chk("w_rst_maddr", 32'(if_w.mem_addr), 30);
        chk("w_rst_daddr", 32'(if_w.dump_addr), 0);
        if_w.dump_ready = 1'b1;
        if_w.cu_state = 5'd19;
        expect_words(1, 30, 4);
        tick();
        if_w.cu_state = '0;
        n = 1;
        for (int k = 0; k < 30 && !if_w.done; k++) begin
            tick();
            n++;
        end
        chk("w_done",     32'(if_w.done), 1);
        chk("w_done_lat", 32'(n), 13);
        chk("w_hs",       32'(hs_w), 4);
        chk("w_q_left",   32'(q_w.size()), 0);

        // watchdog instance, TIMEOUT_CYCLES=50
        rst_d = 1'b0; cyc = 0;
        if_d.dump_ready = 1'b1;
`ifdef MEM_DUMP_WATCHDOG_EN
        expect_words(2, 0, 32);
        while (cyc < 49) tick();
        chk("wd_rden_49",   32'(if_d.mem_rd_en),   0);
        chk("wd_active_49", 32'(if_d.dump_active), 0);
        tick();
        chk("wd_rden_50",   32'(if_d.mem_rd_en),   1);
        chk("wd_tout_50",   32'(if_d.timed_out),   1);
        for (int k = 0; k < 150 && !if_d.done; k++) tick();
        chk("wd_done",      32'(if_d.done),        1);
        chk("wd_tout_end",  32'(if_d.timed_out),   1);
        chk("wd_hs",        32'(hs_d),             32);
        chk("wd_q_left",    32'(q_d.size()),       0);

        rst_d = 1'b1; tick(); rst_d = 1'b0;
        cyc = 0; hs_d = 0; q_d.delete();
        chk("wd2_rst_tout", 32'(if_d.timed_out), 0);
        expect_words(2, 0, 32);
        while (cyc < 49) tick();
        if_d.cu_state = 5'd19;
        tick();
        if_d.cu_state = '0;
        chk("wd2_rden_50",  32'(if_d.mem_rd_en), 1);
        chk("wd2_tout_50",  32'(if_d.timed_out), 0);
        for (int k = 0; k < 150 && !if_d.done; k++) tick();
        chk("wd2_done",     32'(if_d.done),      1);
        chk("wd2_tout_end", 32'(if_d.timed_out), 0);
        chk("wd2_hs",       32'(hs_d),           32);
`else
        while (cyc < 60) tick();
        chk("wd_off_rden",   32'(if_d.mem_rd_en),   0);
        chk("wd_off_active", 32'(if_d.dump_active), 0);
        chk("wd_off_tout",   32'(if_d.timed_out),   0);
        chk("wd_off_hs",     32'(hs_d),             0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Synthesizable end-of-kernel monitor and data-memory dump engine for the tinyGPU `System`. It watches the Scheduler CU state and detects kernel completion, or a watchdog timeout. It then reads a parametrised window of DataMemory through a one-cycle synchronous read port and streams each word out over a valid/ready channel. This replaces fixed-size, testbench-only memory dumps with a reusable block usable in simulation and on FPGA (UART/JTAG sink).

## Interface
Parameters:
- `DATA_WIDTH`, 16, data memory word width
- `ADDR_WIDTH`, 5, data memory address width
- `STATE_WIDTH`, 5, width of CU state bus
- `END_STATE`, 19, CU state code meaning kernel finished
- `BASE_ADDR`, 0, first address dumped
- `DUMP_WORDS`, 32, number of words dumped (1..2^ADDR_WIDTH)
- `TIMEOUT_CYCLES`, 100000, watchdog limit in clock cycles (used only with `MEM_DUMP_WATCHDOG_EN`)

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `cu_state`  in  STATE_WIDTH  current CU state
- `mem_rd_en`  out  1  read strobe to DataMemory
- `mem_addr`  out  ADDR_WIDTH  read address
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after `mem_rd_en`
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  sink accepts word
- `dump_addr`  out  ADDR_WIDTH  address of current dump word
- `dump_data`  out  DATA_WIDTH  current dump word
- `dump_active`  out  1  high from end detection until DONE
- `done`  out  1  all words transferred; held until reset
- `timed_out`  out  1  dump was triggered by watchdog; held until reset

## Operation
- States: RUN, ISSUE, CAPTURE, SEND, DONE.
- RUN: idle. On `cu_state == END_STATE` go to ISSUE with `timed_out`=0. On watchdog expiry go to ISSUE with `timed_out`=1.
- ISSUE: drive `mem_rd_en`=1 and `mem_addr`=current address, then go to CAPTURE.
- CAPTURE: register `mem_rdata` into `dump_data` and `mem_addr` into `dump_addr`, then go to SEND.
- SEND: `dump_valid`=1. `dump_data` and `dump_addr` stay stable until `dump_valid && dump_ready`.
  - On handshake, if this was word `DUMP_WORDS-1`, go to DONE.
  - Otherwise increment the address and go to ISSUE.
- DONE: `done`=1 and `dump_active`=0. Terminal until reset; later `cu_state` values are ignored.
- Address arithmetic: `BASE_ADDR + index`, truncated to ADDR_WIDTH, so the window wraps modulo 2^ADDR_WIDTH. The word counter is `$clog2(DUMP_WORDS+1)` bits wide.
- `mem_rd_en` is 0 in all states except ISSUE. `mem_addr` holds the last-issued value otherwise.

## Timing
- Reset values:
  - state RUN
  - `mem_rd_en`=0, `mem_addr`=BASE_ADDR
  - `dump_valid`=0, `dump_addr`=0, `dump_data`=0
  - `dump_active`=0, `done`=0, `timed_out`=0
  - watchdog count=0, word index=0
- Let cycle t be the cycle in which end is sampled. Then `dump_active`=1 and `mem_rd_en`=1 from cycle t+1, and the first `dump_valid` is in cycle t+3.
- Minimum 3 cycles per word with `dump_ready` tied high. The full dump takes 3·DUMP_WORDS cycles, and `done` rises the cycle after the last handshake.
- `dump_ready` may be asserted before `dump_valid`. It is only sampled in SEND.
- If END_STATE is sampled in the same cycle the watchdog expires, the trigger is a normal end and `timed_out`=0.
- Reset asserted mid-dump aborts the dump. All registers return to reset values on the next edge, and no partial `done` is produced.

## Configuration
- Macro: `MEM_DUMP_WATCHDOG_EN`.
- Defined: a cycle counter runs in RUN only. When it reaches `TIMEOUT_CYCLES-1` without END_STATE, the block triggers the dump and sets `timed_out`=1.
- Undefined: no counter is synthesised, `timed_out` is tied 0, and the block waits in RUN indefinitely.

## Test plan
- Normal end: RAM[i]=i+100, DUMP_WORDS=32, BASE_ADDR=0, `dump_ready`=1, `cu_state`=19 at cycle 10.
  - Expect 32 handshakes with data 100..131 and addresses 0..31.
  - `done`=1 at cycle 10+96+1.
  - `timed_out`=0.
- Backpressure: `dump_ready` low for 5 cycles during word 3.
  - `dump_valid` stays high and `dump_data`/`dump_addr` stay stable.
  - No word is lost or duplicated, and the final count is 32.
- Wrap: BASE_ADDR=30, DUMP_WORDS=4, ADDR_WIDTH=5.
  - Addresses dumped are 30, 31, 0, 1.
- Watchdog (macro defined): TIMEOUT_CYCLES=50, `cu_state` never 19.
  - ISSUE is entered at cycle 50.
  - `timed_out`=1, the dump completes, and `done`=1.
  - Same setup with `cu_state`=19 exactly at the expiry cycle gives `timed_out`=0.
- Reset mid-dump: assert `reset` for 1 cycle during word 5.
  - All outputs return to reset values.
  - A subsequent END_STATE restarts from BASE_ADDR and completes 32 words.
- Terminal: after `done`, toggle `cu_state` through 0..31.
  - No further `mem_rd_en` or `dump_valid`.
  - `done` remains 1.
